// File: rtl/multi_cycle_rv_core.sv
// Multi-cycle RV32I-subset core sharing one req/ready memory port for fetch, load and store.
// Define MC_CORE_PERF_EN to add the perf_cycles / perf_instret counter ports.
module multi_cycle_rv_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_ADDR_W = 8,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  halted,
    output logic                  illegal,
    output logic [31:0]           dbg_pc,
    output logic [2:0]            dbg_state
`ifdef MC_CORE_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_instret
`endif
);

    localparam int unsigned RIDX_W = $clog2(NUM_REGS);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, res_q, npc_q;
    logic        illegal_q;
    logic [31:0] rf_q [NUM_REGS];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    logic        legal, use_rs1, use_rs2, use_rd, reg_ok;
    logic [31:0] imm_dec;

    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        imm_dec = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                imm_dec = {ir_q[31:12], 12'b0};
            end
            OP_JAL: begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
                if (opcode == OP_JALR)      legal = (f3 == 3'b000);
                else if (opcode == OP_LOAD) legal = (f3 == 3'b010);
                else if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101)      legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else                        legal = 1'b1;
            end
            OP_BRANCH: begin
                legal   = (f3 != 3'b010) && (f3 != 3'b011);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            end
            OP_STORE: begin
                legal   = (f3 == 3'b010);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            end
            OP_REG: begin
                legal   = (f7 == 7'b0000000) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_SYSTEM: legal = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);
            default:   legal = 1'b0;
        endcase
    end

    // Register indices beyond NUM_REGS (RV32E) are treated as illegal encodings.
    assign reg_ok = !(use_rs1 && (32'(rs1) >= NUM_REGS)) &&
                    !(use_rs2 && (32'(rs2) >= NUM_REGS)) &&
                    !(use_rd  && (32'(rd)  >= NUM_REGS));

    logic [31:0] op_b, alu, pc_plus4, mem_ea, exec_res, exec_npc;
    logic        eq, lt, ltu, taken;

    assign pc_plus4 = pc_q + 32'd4;
    assign mem_ea   = a_q + imm_q;
    assign op_b     = ((opcode == OP_REG) || (opcode == OP_BRANCH)) ? b_q : imm_q;
    assign eq       = (a_q == b_q);
    assign lt       = ($signed(a_q) < $signed(b_q));
    assign ltu      = (a_q < b_q);

    always_comb begin
        alu = '0;
        case (f3)
            3'b000:  alu = ((opcode == OP_REG) && f7[5]) ? a_q - op_b : a_q + op_b;
            3'b001:  alu = a_q << op_b[4:0];
            3'b010:  alu = {31'b0, $signed(a_q) < $signed(op_b)};
            3'b011:  alu = {31'b0, a_q < op_b};
            3'b100:  alu = a_q ^ op_b;
            3'b101:  alu = f7[5] ? 32'($signed(a_q) >>> op_b[4:0]) : a_q >> op_b[4:0];
            3'b110:  alu = a_q | op_b;
            default: alu = a_q & op_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        exec_npc = pc_plus4;
        case (opcode)
            OP_LUI:           exec_res = imm_q;
            OP_AUIPC:         exec_res = pc_q + imm_q;
            OP_JAL, OP_JALR:  exec_res = pc_plus4;
            default:          exec_res = alu;
        endcase
        if (opcode == OP_JAL)       exec_npc = pc_q + imm_q;
        else if (opcode == OP_JALR) exec_npc = mem_ea & ~32'd1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: state_d = (legal && reg_ok) ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (opcode)
                    OP_BRANCH:          state_d = S_FETCH;
                    OP_LOAD, OP_STORE:  state_d = S_MEM;
                    OP_SYSTEM:          state_d = S_HALT;
                    default:            state_d = S_WB;
                endcase
            end
            S_MEM:    if (mem_ready) state_d = (opcode == OP_STORE) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            npc_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_FETCH: if (mem_ready) ir_q <= mem_rdata;
                S_DECODE: begin
                    a_q   <= rf_q[rs1[RIDX_W-1:0]];
                    b_q   <= rf_q[rs2[RIDX_W-1:0]];
                    imm_q <= imm_dec;
                    if (!(legal && reg_ok)) illegal_q <= 1'b1;
                end
                S_EXEC: begin
                    res_q <= exec_res;
                    npc_q <= exec_npc;
                    if (opcode == OP_BRANCH) pc_q <= taken ? pc_q + imm_q : pc_plus4;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (opcode == OP_STORE) pc_q <= pc_plus4;
                        else                    res_q <= mem_rdata;
                    end
                end
                S_WB:    pc_q <= npc_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if ((state_q == S_WB) && (rd != 5'd0)) begin
            rf_q[rd[RIDX_W-1:0]] <= res_q;
        end
    end

    // Gated by reset so an access in flight is withdrawn the moment reset asserts.
    logic [MEM_ADDR_W-1:0] addr_sel;

    assign addr_sel  = (state_q == S_MEM) ? mem_ea[MEM_ADDR_W-1:0] : pc_q[MEM_ADDR_W-1:0];
    assign mem_req   = reset && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we    = reset && (state_q == S_MEM) && (opcode == OP_STORE);
    assign mem_addr  = addr_sel & ~MEM_ADDR_W'(3);
    assign mem_wdata = b_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign dbg_pc    = pc_q;
    assign dbg_state = state_q;

`ifdef MC_CORE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles  <= '0;
            perf_instret <= '0;
        end else begin
            if (state_q != S_HALT) perf_cycles <= perf_cycles + 32'd1;
            if (((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) &&
                (state_d == S_FETCH)) begin
                perf_instret <= perf_instret + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_cycle_rv_core.sv
// Directed bench for multi_cycle_rv_core: wait-state memory model plus an RV32E instance.
module tb_multi_cycle_rv_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mem_req, mem_we, mem_ready, halted, illegal;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, dbg_pc;
    logic [2:0]  dbg_state;

    logic        s_req, s_we, s_ready, s_halted, s_illegal;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata, s_rdata, s_pc;
    logic [2:0]  s_state;

`ifdef MC_CORE_PERF_EN
    logic [31:0] perf_cycles, perf_instret, s_perf_cycles, s_perf_instret;
`endif

    multi_cycle_rv_core #(
        .RESET_PC   (32'h0000_0040),
        .MEM_ADDR_W (8),
        .NUM_REGS   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .illegal   (illegal),
        .dbg_pc    (dbg_pc),
        .dbg_state (dbg_state)
`ifdef MC_CORE_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_instret (perf_instret)
`endif
    );

    // RV32E instance that only ever sees ADD x17,x0,x0.
    assign s_rdata = 32'h0000_08B3;
    assign s_ready = 1'b1;

    multi_cycle_rv_core #(
        .RESET_PC   (32'h0000_0000),
        .MEM_ADDR_W (8),
        .NUM_REGS   (16)
    ) dut16 (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (s_req),
        .mem_we    (s_we),
        .mem_addr  (s_addr),
        .mem_wdata (s_wdata),
        .mem_rdata (s_rdata),
        .mem_ready (s_ready),
        .halted    (s_halted),
        .illegal   (s_illegal),
        .dbg_pc    (s_pc),
        .dbg_state (s_state)
`ifdef MC_CORE_PERF_EN
        ,
        .perf_cycles  (s_perf_cycles),
        .perf_instret (s_perf_instret)
`endif
    );

    logic [31:0] mem [64];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;
    int unsigned wait_n = 0;
    int unsigned wcnt = 0;

    assign mem_rdata = mem[mem_addr[7:2]];
    assign mem_ready = mem_req && (wcnt == wait_n);

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (mem_req && mem_we && mem_ready) mem[mem_addr[7:2]] <= mem_wdata;
        if (!mem_req || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(negedge clk);
        poke_en  = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output int cycles);
        cycles = 0;
        while (dbg_state !== st && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (dbg_state !== st) begin
            total++;
            bad++;
            $display("FAIL wait_state: observed=%0d expected=%0d", dbg_state, st);
        end
    endtask

    task automatic wait_fetch_pc(input logic [31:0] pc, input int budget, output int cycles);
        cycles = 0;
        while (!(dbg_state === 3'd0 && dbg_pc === pc) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (!(dbg_state === 3'd0 && dbg_pc === pc)) begin
            total++;
            bad++;
            $display("FAIL wait_fetch_pc: observed=%h expected=%h", dbg_pc, pc);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c;
        reset = 1'b0;
        @(negedge clk);
        poke(6'd16, enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));          // 0x40 ADDI x1,x0,5
        poke(6'd17, enc_i(12'hFF9, 5'd1, 3'd0, 5'd2, 7'h13));        // 0x44 ADDI x2,x1,-7
        poke(6'd18, enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33));     // 0x48 ADD x3,x1,x2
        poke(6'd19, enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13));          // 0x4C ADDI x0,x0,9
        poke(6'd20, enc_s(12'd8, 5'd1, 5'd0, 3'd2));                 // 0x50 SW x1,8(x0)
        poke(6'd21, enc_i(12'd8, 5'd0, 3'd2, 5'd4, 7'h03));          // 0x54 LW x4,8(x0)
        poke(6'd22, enc_b(13'd16, 5'd2, 5'd1, 3'd0));                // 0x58 BEQ x1,x2,+16
        poke(6'd23, enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'h13));          // 0x5C ADDI x6,x0,1
        poke(6'd24, enc_i(12'hFFF, 5'd0, 3'd0, 5'd7, 7'h13));        // 0x60 ADDI x7,x0,-1
        poke(6'd25, enc_j(21'd12, 5'd0));                            // 0x64 JAL x0,+12
        poke(6'd26, enc_i(12'h014, 5'd1, 3'd0, 5'd5, 7'h67));        // 0x68 JALR x5,0x14(x1)
        poke(6'd28, enc_b(13'h1FF8, 5'd6, 5'd7, 3'd4));              // 0x70 BLT x7,x6,-8
        poke(6'd6, 32'h0000_0073);                                   // 0x18 ECALL
        poke(6'd2, 32'h0000_0000);

        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_pc", dbg_pc, 32'h40);
        check("rst_state", 32'(dbg_state), 32'd0);

        reset = 1'b1;
        #1;
        check("c1_req", 32'(mem_req), 32'd1);
        check("c1_addr", 32'(mem_addr), 32'h40);
        check("c1_halted", 32'(halted), 32'd0);

        step(12);
        check("alu_pc", dbg_pc, 32'h4C);
        check("alu_state", 32'(dbg_state), 32'd0);
        check("x1", dut.rf_q[1], 32'd5);
        check("x2", dut.rf_q[2], 32'hFFFF_FFFE);
        check("x3", dut.rf_q[3], 32'd3);
`ifdef MC_CORE_PERF_EN
        check("perf_instret", perf_instret, 32'd3);
        check("perf_cycles", perf_cycles, 32'd12);
`endif
        check("rv32e_halted", 32'(s_halted), 32'd1);
        check("rv32e_illegal", 32'(s_illegal), 32'd1);
        check("rv32e_req", 32'(s_req), 32'd0);

        step(4);
        check("x0_write", dut.rf_q[0], 32'd0);
        check("x0_pc", dbg_pc, 32'h50);

        wait_n = 2;
        wait_state(3'd3, 50, c);
        check("sw_to_mem_cycles", 32'(c), 32'd5);
        for (int i = 0; i < 3; i++) begin
            check("sw_wait_state", 32'(dbg_state), 32'd3);
            check("sw_wait_req", 32'(mem_req), 32'd1);
            check("sw_wait_we", 32'(mem_we), 32'd1);
            check("sw_wait_addr", 32'(mem_addr), 32'h08);
            check("sw_wait_wdata", mem_wdata, 32'd5);
            step(1);
        end
        wait_fetch_pc(32'h58, 50, c);
        check("lw_cycles", 32'(c), 32'd9);
        check("sw_mem", mem[2], 32'd5);
        check("x4", dut.rf_q[4], 32'd5);

        wait_n = 0;
        step(3);
        check("beq_nt_pc", dbg_pc, 32'h5C);
        check("beq_nt_state", 32'(dbg_state), 32'd0);
        step(12);
        check("jal_pc", dbg_pc, 32'h70);
        check("x7", dut.rf_q[7], 32'hFFFF_FFFF);
        check("jal_x0", dut.rf_q[0], 32'd0);
        step(3);
        check("blt_taken_pc", dbg_pc, 32'h68);
        step(4);
        check("jalr_pc", dbg_pc, 32'h18);
        check("x5", dut.rf_q[5], 32'h6C);
        step(3);
        check("ecall_halted", 32'(halted), 32'd1);
        check("ecall_illegal", 32'(illegal), 32'd0);
        check("ecall_state", 32'(dbg_state), 32'd5);
        check("ecall_req", 32'(mem_req), 32'd0);
        step(5);
        check("halt_pc", dbg_pc, 32'h18);

        reset = 1'b0;
        poke(6'd16, 32'h0000_0000);
        reset = 1'b1;
        step(2);
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_flag", 32'(illegal), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("ill_req", 32'(mem_req), 32'd0);
            step(1);
        end

        reset = 1'b0;
        poke(6'd16, enc_s(12'd8, 5'd1, 5'd0, 3'd2));
        wait_n = 3;
        reset = 1'b1;
        wait_state(3'd3, 50, c);
        check("rst_mem_cycles", 32'(c), 32'd6);
        step(1);
        reset = 1'b0;
        #1;
        check("rstmid_req", 32'(mem_req), 32'd0);
        check("rstmid_we", 32'(mem_we), 32'd0);
        check("rstmid_state", 32'(dbg_state), 32'd0);
        check("rstmid_illegal", 32'(illegal), 32'd0);
        step(2);
        check("rstmid_mem", mem[2], 32'd5);
        reset = 1'b1;
        #1;
        check("rel_pc", dbg_pc, 32'h40);
        check("rel_req", 32'(mem_req), 32'd1);
        check("rel_addr", 32'(mem_addr), 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
